// File: rtl/rand_delay_gen.sv
// rand_delay_gen: random-delay generator for the reaction-time tester.
// A free-running maximal-length Fibonacci LFSR is mapped into the range
// [MIN_VAL, MAX_VAL]. On entry to the WAIT state of the main state machine,
// that many prescaled ticks are counted down. A one-cycle expire pulse is
// then issued. Runtime reseeding and abort on early WAIT exit are supported.
// Optional build macro: RAND_FIXED_DELAY_EN forces the delay to MIN_VAL
// (the LFSR still runs and still reseeds).
module rand_delay_gen #(
  parameter int unsigned WIDTH     = 14,
  parameter int unsigned SEED      = 32'h1ACE,
  parameter int unsigned MIN_VAL   = 1000,
  parameter int unsigned MAX_VAL   = 5000,
  parameter int unsigned TICK_DIV  = 50000,
  parameter logic [2:0]  WAIT_CODE = 3'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       state_in,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_val,
  output logic [WIDTH-1:0] rand_num,
  output logic             busy,
  output logic             expire
);

  localparam int unsigned RANGE = MAX_VAL - MIN_VAL + 1;
  localparam int unsigned PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [WIDTH-1:0]   SEED_W  = WIDTH'(SEED);
  localparam logic [WIDTH-1:0]   MIN_W   = WIDTH'(MIN_VAL);
  localparam logic [2*WIDTH-1:0] RANGE_X = (2*WIDTH)'(RANGE);
  localparam logic [PW-1:0]      TDM1    = PW'(TICK_DIV - 1);

  // Reject illegal configurations at elaboration.
  if (WIDTH < 8 || WIDTH > 16) begin : g_bad_width
    $error("rand_delay_gen: WIDTH must be 8..16");
  end
  if (SEED_W == '0) begin : g_bad_seed
    $error("rand_delay_gen: SEED must be non-zero within WIDTH bits");
  end
  if (MIN_VAL < 1 || MIN_VAL > MAX_VAL || MAX_VAL >= (32'd1 << WIDTH)) begin : g_bad_range
    $error("rand_delay_gen: need 1 <= MIN_VAL <= MAX_VAL < 2**WIDTH");
  end
  if (TICK_DIV < 1) begin : g_bad_div
    $error("rand_delay_gen: TICK_DIV must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Feedback bit for the maximal-length polynomial of the configured width.
  // The value is zero-extended so every tap index stays in range for any WIDTH.
  function automatic logic lfsr_fb(input logic [WIDTH-1:0] v);
    logic [15:0] x;
    x = 16'(v);
    case (WIDTH)
      8:       lfsr_fb = x[7]  ^ x[5]  ^ x[4]  ^ x[3];
      9:       lfsr_fb = x[8]  ^ x[4];
      10:      lfsr_fb = x[9]  ^ x[6];
      11:      lfsr_fb = x[10] ^ x[8];
      12:      lfsr_fb = x[11] ^ x[10] ^ x[9]  ^ x[3];
      13:      lfsr_fb = x[12] ^ x[11] ^ x[10] ^ x[7];
      14:      lfsr_fb = x[13] ^ x[12] ^ x[11] ^ x[1];
      15:      lfsr_fb = x[14] ^ x[13];
      default: lfsr_fb = x[15] ^ x[14] ^ x[12] ^ x[3];
    endcase
  endfunction

  logic [WIDTH-1:0]   r_lfsr;
  logic [2:0]         r_prev_state;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_rand;
  logic               r_busy;
  logic               r_expire;
  logic [PW-1:0]      r_presc;
  logic [WIDTH-1:0]   r_ticks;

  logic [WIDTH-1:0]   w_rand_nxt;
  logic               w_busy_nxt;
  logic               w_expire_nxt;
  logic [PW-1:0]      w_presc_nxt;
  logic [WIDTH-1:0]   w_ticks_nxt;

  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH-1:0]   w_mapped;
  logic               w_in_wait;
  logic               w_entry;
  logic               w_tick_end;
  logic               w_last;

  // Range mapping: the full 2*WIDTH product keeps every LFSR value inside the range.
  assign w_product = {{WIDTH{1'b0}}, r_lfsr} * RANGE_X;
`ifdef RAND_FIXED_DELAY_EN
  assign w_mapped  = MIN_W;
`else
  assign w_mapped  = MIN_W + w_product[2*WIDTH-1:WIDTH];
`endif

  assign w_in_wait  = (state_in == WAIT_CODE);
  assign w_entry    = w_in_wait && (r_prev_state != WAIT_CODE);
  assign w_tick_end = (r_presc == '0);
  assign w_last     = w_tick_end && (r_ticks == WIDTH'(1));

  // LFSR: a reseed wins over the shift; a zero seed falls back to SEED so the register never holds zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= SEED_W;
    end else if (seed_load) begin
      r_lfsr <= (seed_val == '0) ? SEED_W : seed_val;
    end else begin
      r_lfsr <= {r_lfsr[WIDTH-2:0], lfsr_fb(r_lfsr)};
    end
  end

  // Previous main-FSM state, used to detect the WAIT entry edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_state <= 3'd0;
    end else begin
      r_prev_state <= state_in;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: leaving WAIT always returns to IDLE, which aborts any countdown.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_entry) w_state_nxt = S_COUNT;
      end
      S_COUNT: begin
        if (!w_in_wait)  w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!w_in_wait) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath next values: latch the sample on entry, then run the prescaled countdown.
  always_comb begin
    w_rand_nxt   = r_rand;
    w_busy_nxt   = r_busy;
    w_expire_nxt = 1'b0;
    w_presc_nxt  = r_presc;
    w_ticks_nxt  = r_ticks;
    case (r_state)
      S_IDLE: begin
        if (w_entry) begin
          w_rand_nxt  = w_mapped;
          w_ticks_nxt = w_mapped;
          w_presc_nxt = TDM1;
          w_busy_nxt  = 1'b1;
        end
      end
      S_COUNT: begin
        if (!w_in_wait) begin
          w_busy_nxt = 1'b0;
        end else begin
          if (w_tick_end) begin
            w_presc_nxt = TDM1;
            w_ticks_nxt = r_ticks - WIDTH'(1);
          end else begin
            w_presc_nxt = r_presc - PW'(1);
          end
          if (w_last) begin
            w_expire_nxt = 1'b1;
            w_busy_nxt   = 1'b0;
          end
        end
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rand   <= '0;
      r_busy   <= 1'b0;
      r_expire <= 1'b0;
      r_presc  <= '0;
      r_ticks  <= '0;
    end else begin
      r_rand   <= w_rand_nxt;
      r_busy   <= w_busy_nxt;
      r_expire <= w_expire_nxt;
      r_presc  <= w_presc_nxt;
      r_ticks  <= w_ticks_nxt;
    end
  end

  assign rand_num = r_rand;
  assign busy     = r_busy;
  assign expire   = r_expire;

endmodule

// File: tb/tb_rand_delay_gen.sv
// Self-checking bench for rand_delay_gen (WIDTH=8, SEED=1, range 3..10, TICK_DIV=4).
module tb_rand_delay_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] state_in = 3'd0;
  logic       seed_load = 1'b0;
  logic [7:0] seed_val = 8'h00;
  logic [7:0] rand_num;
  logic       busy;
  logic       expire;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_lfsr = 8'h01;
  logic [7:0] m_prev = 8'h01;

  rand_delay_gen #(
    .WIDTH(8), .SEED(32'h01), .MIN_VAL(3), .MAX_VAL(10), .TICK_DIV(4), .WAIT_CODE(3'd1)
  ) dut (
    .clk(clk), .rst(rst), .state_in(state_in), .seed_load(seed_load),
    .seed_val(seed_val), .rand_num(rand_num), .busy(busy), .expire(expire)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  function automatic logic [7:0] m_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Reference mapping: 3 + floor(v * 8 / 256).
  function automatic int ref_map(input logic [7:0] v);
    return 3 + (int'(v) * 8) / 256;
  endfunction

  // One clock: advance the LFSR model with the inputs seen at the edge, then sample 1ns later.
  task automatic step();
    @(posedge clk);
    m_prev = m_lfsr;
    if (rst)            m_lfsr = 8'h01;
    else if (seed_load) m_lfsr = (seed_val == 8'h00) ? 8'h01 : seed_val;
    else                m_lfsr = m_next(m_lfsr);
    #1;
  endtask

  // Called one sample after the entry edge: checks latch, latency, pulse width and DONE hold.
  task automatic run_count(input string tag, input int exp_n, input bit mid_seed);
    int k;
    int hi;
    check_val({tag, "_rand"}, 32'(rand_num), 32'(exp_n));
    check_val({tag, "_busy_up"}, 32'(busy), 32'd1);
    k = 0;
    while (k < 200 && expire !== 1'b1) begin
      if (mid_seed && k == 10) begin
        seed_load = 1'b1;
        seed_val  = 8'hC3;
      end
      step();
      seed_load = 1'b0;
      k++;
    end
    check_val({tag, "_latency"}, 32'(k), 32'(exp_n * 4));
    check_val({tag, "_busy_dn"}, 32'(busy), 32'd0);
    step();
    check_val({tag, "_pulse1"}, 32'(expire), 32'd0);
    hi = 0;
    repeat (20) begin
      step();
      if (expire || busy) hi++;
    end
    check_val({tag, "_done_hold"}, 32'(hi), 32'd0);
    state_in = 3'd2;
    step();
    state_in = 3'd0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen [256];
    int hits [256];
    int rep, zer, trk, bad, hi, e;
    logic [7:0] v;

    // Reset state
    #12;
    check_val("rst_rand", 32'(rand_num), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_expire", 32'(expire), 32'd0);
    check_val("rst_lfsr", 32'(dut.r_lfsr), 32'h01);
    rst = 1'b0;

    // LFSR period
    foreach (seen[i]) seen[i] = 1'b0;
    seen[1] = 1'b1;
    rep = 0; zer = 0; trk = 0;
    for (int i = 1; i <= 255; i++) begin
      step();
      v = dut.r_lfsr;
      if (i == 4) check_val("lfsr_step4", 32'(v), 32'h11);
      if (i == 7) check_val("lfsr_step7", 32'(v), 32'h8E);
      if (v == 8'h00) zer++;
      if (v !== m_lfsr) trk++;
      if (i < 255) begin
        if (seen[v]) rep++;
        seen[v] = 1'b1;
      end
    end
    check_val("lfsr_wrap", 32'(dut.r_lfsr), 32'h01);
    check_val("lfsr_zero", 32'(zer), 32'd0);
    check_val("lfsr_repeat", 32'(rep), 32'd0);
    check_val("lfsr_track", 32'(trk), 32'd0);

    // Reseed and zero-seed fallback
    seed_load = 1'b1; seed_val = 8'h5A;
    step();
    check_val("seed_5a", 32'(dut.r_lfsr), 32'h5A);
    seed_val = 8'h00;
    step();
    seed_load = 1'b0;
    check_val("seed_zero", 32'(dut.r_lfsr), 32'h01);

    // Minimum delay: sample 0x1F -> 3 ticks
    seed_load = 1'b1; seed_val = 8'h1F;
    step();
    seed_load = 1'b0; state_in = 3'd1;
    step();
    run_count("min", 3, 1'b0);

    // Middle delay: sample 0x40 -> 5 ticks
    seed_load = 1'b1; seed_val = 8'h40;
    step();
    seed_load = 1'b0; state_in = 3'd1;
    step();
    run_count("mid", 5, 1'b0);

    // Same-cycle seed on the entry edge: sample uses 0xFF -> 10 ticks, LFSR becomes 0x5A
    seed_load = 1'b1; seed_val = 8'hFF;
    step();
    seed_val = 8'h5A; state_in = 3'd1;
    step();
    seed_load = 1'b0;
    check_val("samecyc_lfsr", 32'(dut.r_lfsr), 32'h5A);
    run_count("max", 10, 1'b0);

    // Reseed while counting does not disturb the countdown
    state_in = 3'd1;
    step();
    run_count("reseed", ref_map(m_prev), 1'b1);
    check_val("reseed_lfsr", 32'(dut.r_lfsr), 32'(m_lfsr));

    // Abort after 5 cycles, then re-entry takes a fresh sample
    state_in = 3'd1;
    step();
    check_val("abort_rand", 32'(rand_num), 32'(ref_map(m_prev)));
    repeat (5) step();
    check_val("abort_busy_pre", 32'(busy), 32'd1);
    state_in = 3'd2;
    step();
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_expire", 32'(expire), 32'd0);
    hi = 0;
    repeat (60) begin
      step();
      if (expire) hi++;
    end
    check_val("abort_no_expire", 32'(hi), 32'd0);
    state_in = 3'd1;
    step();
    check_val("reentry_rand", 32'(rand_num), 32'(ref_map(m_prev)));
    check_val("reentry_busy", 32'(busy), 32'd1);
    state_in = 3'd0;
    step();

    // Asynchronous reset mid-count
    state_in = 3'd1;
    step();
    repeat (6) step();
    check_val("areset_busy_pre", 32'(busy), 32'd1);
    #3;
    rst = 1'b1; state_in = 3'd0; m_lfsr = 8'h01;
    #1;
    check_val("areset_busy", 32'(busy), 32'd0);
    check_val("areset_expire", 32'(expire), 32'd0);
    check_val("areset_rand", 32'(rand_num), 32'd0);
    check_val("areset_lfsr", 32'(dut.r_lfsr), 32'h01);
    step();
    rst = 1'b0;
    hi = 0;
    repeat (60) begin
      step();
      if (expire || busy) hi++;
    end
    check_val("areset_quiet", 32'(hi), 32'd0);

    // Range sweep at random LFSR phases
    foreach (hits[i]) hits[i] = 0;
    bad = 0;
    for (int n = 0; n < 500; n++) begin
      state_in = 3'd1;
      step();
      e = ref_map(m_prev);
      check_val("sweep_rand", 32'(rand_num), 32'(e));
      if (rand_num < 8'd3 || rand_num > 8'd10) bad++;
      hits[rand_num]++;
      state_in = 3'd0;
      repeat ($urandom_range(1, 7)) step();
    end
    check_val("sweep_range", 32'(bad), 32'd0);
    for (int r = 3; r <= 10; r++) begin
      check_val($sformatf("sweep_hit%0d", r), 32'(hits[r] > 0), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
